step_sequencer: RTL

- Parametrised successor to the fixed one-hot 5-step cycle counter in the processor control path.
- Variable-length instruction sequencer: per-instruction step skipping, memory request/acknowledge handshake with timeout, multi-cycle ALU wait, halt, pause/resume.
- Consumes op-class flags from the decoder; drives the fetch, execute, memory and write-back strobes consumed by datapath control.

---
 rtl/step_sequencer_pkg.sv | 30 +++
 rtl/step_sequencer_wait_timer.sv | 30 +++
 rtl/step_sequencer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/step_sequencer_pkg.sv
// Shared types for the instruction step sequencer: state codes, latched op flags,
// default handshake timeout and the retire target helper.
package step_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } seq_state_e;

  localparam int MEM_TMO_DEFAULT = 255;

  // HLT and NOP are resolved inside DECODE, so only these flags are carried on
  typedef struct packed {
    logic mem;
    logic store;
    logic wb;
    logic multi;
  } op_flags_t;

  function automatic seq_state_e retire_target(input logic run);
    return run ? S_FETCH : S_IDLE;
  endfunction

endpackage

// File: rtl/step_sequencer_wait_timer.sv
// Handshake wait counter shared by FETCH and MEM; flags the last cycle an
// acknowledge may still arrive before the sequencer gives up.
module wait_timer #(
  parameter int TMO_W   = 8,
  parameter int MEM_TMO = 255
) (
  input  logic iClk,
  input  logic nRst,
  input  logic iClr,
  input  logic iInc,
  output logic oExpire
);

  localparam logic [TMO_W-1:0] LAST = TMO_W'(MEM_TMO - 1);

  logic [TMO_W-1:0] cnt;

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      cnt <= '0;
    end else if (iClr) begin
      cnt <= '0;
    end else if (iInc && !oExpire) begin
      cnt <= cnt + TMO_W'(1);
    end
  end

  assign oExpire = (cnt == LAST);

endmodule

// File: rtl/step_sequencer.sv
// Variable-length instruction step sequencer with memory handshake timeout.
// IDLE|wait run  FETCH|read IR  DECODE|latch ops  EXEC|ALU  MEM|ld/st  WB|rf write  HALT|wait run edge  FAULT|timeout, reset only
module step_sequencer
  import step_sequencer_pkg::*;
#(
  parameter int TMO_W   = 8,
  parameter int MEM_TMO = MEM_TMO_DEFAULT,
  parameter int RET_W   = 32
) (
  input  logic             iClk,
  input  logic             nRst,
  input  logic             iRun,
  input  logic             iMemAck,
  input  logic             iAluDone,
  input  logic             iOpMem,
  input  logic             iOpStore,
  input  logic             iOpWb,
  input  logic             iOpMulti,
  input  logic             iOpHalt,
  input  logic             iOpNop,
  output logic [2:0]       oState,
  output logic             oMemReq,
  output logic             oMemWr,
  output logic             oIR_en,
  output logic             oPC_en,
  output logic             oAluStart,
  output logic             oRF_Write,
  output logic             oHalted,
  output logic             oFault,
  output logic [RET_W-1:0] oRetired
);

  seq_state_e       state, state_nxt;
  op_flags_t        ops_q;
  logic             run_q;
  logic             exec_busy;
  logic             retire;
  logic             tmr_clr, tmr_inc, tmr_exp;
  logic [RET_W-1:0] retired;

  wait_timer #(
    .TMO_W  (TMO_W),
    .MEM_TMO(MEM_TMO)
  ) u_wait_timer (
    .iClk   (iClk),
    .nRst   (nRst),
    .iClr   (tmr_clr),
    .iInc   (tmr_inc),
    .oExpire(tmr_exp)
  );

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      state     <= S_IDLE;
      ops_q     <= '0;
      run_q     <= 1'b0;
      exec_busy <= 1'b0;
      retired   <= '0;
    end else begin
      state     <= state_nxt;
      run_q     <= iRun;
      exec_busy <= (state == S_EXEC) && (state_nxt == S_EXEC);
      if (state == S_DECODE) begin
        ops_q <= '{mem: iOpMem, store: iOpStore, wb: iOpWb, multi: iOpMulti};
      end
      if (retire) begin
        retired <= retired + RET_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    oMemReq   = 1'b0;
    oMemWr    = 1'b0;
    oIR_en    = 1'b0;
    oPC_en    = 1'b0;
    oAluStart = 1'b0;
    oRF_Write = 1'b0;
    oHalted   = 1'b0;
    oFault    = 1'b0;
    case (state)
      S_IDLE: begin
        if (iRun) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        oMemReq = 1'b1;
        if (iMemAck) begin
          oIR_en    = 1'b1;
          oPC_en    = 1'b1;
          state_nxt = S_DECODE;
        end else if (tmr_exp) begin
          state_nxt = S_FAULT;
        end
      end
      S_DECODE: begin
        if (iOpHalt)     state_nxt = S_HALT;
        else if (iOpNop) retire = 1'b1;
        else             state_nxt = S_EXEC;
      end
      S_EXEC: begin
        oAluStart = !exec_busy;
        if (!ops_q.multi || iAluDone) begin
          if (ops_q.mem)     state_nxt = S_MEM;
          else if (ops_q.wb) state_nxt = S_WB;
          else               retire = 1'b1;
        end
      end
      S_MEM: begin
        oMemReq = 1'b1;
        oMemWr  = ops_q.store;
        if (iMemAck) begin
          if (ops_q.wb) state_nxt = S_WB;
          else          retire = 1'b1;
        end else if (tmr_exp) begin
          state_nxt = S_FAULT;
        end
      end
      S_WB: begin
        oRF_Write = 1'b1;
        retire    = 1'b1;
      end
      S_HALT: begin
        oHalted = 1'b1;
        if (iRun && !run_q) state_nxt = S_FETCH;
      end
      S_FAULT: begin
        oFault = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
    // run is only looked at on an instruction boundary
    if (retire) state_nxt = retire_target(iRun);
  end

  assign tmr_clr  = ((state_nxt == S_FETCH) || (state_nxt == S_MEM)) && (state_nxt != state);
  assign tmr_inc  = ((state == S_FETCH) || (state == S_MEM)) && !iMemAck;
  assign oState   = state;
  assign oRetired = retired;

endmodule
